hazard_stall_ctrl: RTL



---
 rtl/hazard_pkg.sv | 55 +++++
 rtl/hazard_slot_pipe.sv | 42 ++++
 rtl/hazard_stall_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared decode constants, forwarding encodings and FSM state for the hazard/stall controller.
// Instruction fields: op[31:29] imm[28] rd[27:23] rs1[22:18] rs2[17:13].
package hazard_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_NOP1 = 3'b110;
  localparam logic [2:0] OP_NOP2 = 3'b111;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 29;
  localparam int IMM_BIT = 28;
  localparam int RD_HI   = 27;
  localparam int RD_LO   = 23;
  localparam int RS1_HI  = 22;
  localparam int RS1_LO  = 18;
  localparam int RS2_HI  = 17;
  localparam int RS2_LO  = 13;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Wide enough for MUL_LAT-1 with MUL_LAT up to 8.
  localparam int MUL_CNT_W = 4;

  typedef enum logic {RUN, MUL_WAIT} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       wr;
    logic       use1;
    logic       use2;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr, input logic valid);
    dec_t d;
    d.op   = instr[OP_HI:OP_LO];
    d.rd   = instr[RD_HI:RD_LO];
    d.rs1  = instr[RS1_HI:RS1_LO];
    d.rs2  = instr[RS2_HI:RS2_LO];
    d.wr   = valid && (d.op != OP_NOP1) && (d.op != OP_NOP2);
    d.use1 = valid && (d.op != OP_MOV);
    d.use2 = valid && !instr[IMM_BIT] && (d.op != OP_MOV);
    return d;
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// Three-slot (EX/MEM/WB) destination-register tracker; one-cycle update per edge.
// ex_hold freezes EX and drops a bubble into MEM; ex_bubble loads an invalid EX entry.
module hazard_slot_pipe
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_hold,
  input  logic       ex_bubble,
  input  logic       id_wr,
  input  logic [4:0] id_rd,
  output logic       ex_v,
  output logic [4:0] ex_rd,
  output logic       mem_v,
  output logic [4:0] mem_rd,
  output logic       wb_v,
  output logic [4:0] wb_rd
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v   <= 1'b0;
      ex_rd  <= '0;
      mem_v  <= 1'b0;
      mem_rd <= '0;
      wb_v   <= 1'b0;
      wb_rd  <= '0;
    end else begin
      wb_v  <= mem_v;
      wb_rd <= mem_rd;
      if (ex_hold) begin
        mem_v <= 1'b0;
      end else begin
        mem_v  <= ex_v;
        mem_rd <= ex_rd;
        ex_v   <= id_wr & ~ex_bubble;
        ex_rd  <= id_rd;
      end
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// RAW hazard detection, stall/bubble sequencing and multi-cycle MUL control for the 5-stage core.
// Optional operand forwarding is enabled by defining HAZARD_FWD_EN (default: stall on every RAW).
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             ex_hold,
  output logic             exmem_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             id_bypass_a,
  output logic             id_bypass_b,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam bit                   MUL_MULTI = (MUL_LAT > 1);
  localparam logic [MUL_CNT_W-1:0] MUL_START = MUL_CNT_W'(MUL_LAT - 1);

  dec_t dec;
  assign dec = decode(id_instr, id_valid);

  logic unused_imm_bits;
  assign unused_imm_bits = ^id_instr[12:0];

  logic       ex_v, mem_v, wb_v;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;

  assign a_ex  = dec.use1 & ex_v  & (dec.rs1 == ex_rd);
  assign a_mem = dec.use1 & mem_v & (dec.rs1 == mem_rd);
  assign a_wb  = dec.use1 & wb_v  & (dec.rs1 == wb_rd);
  assign b_ex  = dec.use2 & ex_v  & (dec.rs2 == ex_rd);
  assign b_mem = dec.use2 & mem_v & (dec.rs2 == mem_rd);
  assign b_wb  = dec.use2 & wb_v  & (dec.rs2 == wb_rd);

  state_t               state, state_nxt;
  logic [MUL_CNT_W-1:0] mcnt, mcnt_nxt;
  logic                 raw_stall;
  logic                 slot_bubble;

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  assign raw_stall = 1'b0;

  // Youngest producer wins: EX/MEM over MEM/WB over the ID-stage bypass.
  always_comb begin
    fwd_a_nxt = a_ex ? FWD_EXMEM : (a_mem ? FWD_MEMWB : FWD_IDEX);
    fwd_b_nxt = b_ex ? FWD_EXMEM : (b_mem ? FWD_MEMWB : FWD_IDEX);
  end

  // Selects are registered with the instruction entering ID/EX and held while EX is frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_sel <= FWD_IDEX;
      fwd_b_sel <= FWD_IDEX;
    end else if (state == RUN) begin
      fwd_a_sel <= fwd_a_nxt;
      fwd_b_sel <= fwd_b_nxt;
    end
  end

  assign id_bypass_a = (state == RUN) & a_wb & ~a_ex & ~a_mem;
  assign id_bypass_b = (state == RUN) & b_wb & ~b_ex & ~b_mem;
`else
  // Producer in WB still counts: the register file writes on the same edge ID/EX samples it.
  assign raw_stall   = a_ex | a_mem | a_wb | b_ex | b_mem | b_wb;
  assign fwd_a_sel   = FWD_IDEX;
  assign fwd_b_sel   = FWD_IDEX;
  assign id_bypass_a = 1'b0;
  assign id_bypass_b = 1'b0;
`endif

  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    idex_bubble  = 1'b0;
    ex_hold      = 1'b0;
    exmem_bubble = 1'b0;
    slot_bubble  = 1'b0;
    state_nxt    = state;
    mcnt_nxt     = mcnt;
    case (state)
      RUN: begin
        if (raw_stall) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          slot_bubble = 1'b1;
        end else if (MUL_MULTI && dec.wr && (dec.op == OP_MUL)) begin
          state_nxt = MUL_WAIT;
          mcnt_nxt  = MUL_START;
        end
      end
      MUL_WAIT: begin
        pc_hold      = 1'b1;
        ifid_hold    = 1'b1;
        ex_hold      = 1'b1;
        exmem_bubble = 1'b1;
        mcnt_nxt     = mcnt - MUL_CNT_W'(1);
        if (mcnt == MUL_CNT_W'(1)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      mcnt  <= '0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  assign mul_busy = (state == MUL_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (pc_hold && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  hazard_slot_pipe u_slots (
    .clk       (clk),
    .reset     (reset),
    .ex_hold   (ex_hold),
    .ex_bubble (slot_bubble),
    .id_wr     (dec.wr),
    .id_rd     (dec.rd),
    .ex_v      (ex_v),
    .ex_rd     (ex_rd),
    .mem_v     (mem_v),
    .mem_rd    (mem_rd),
    .wb_v      (wb_v),
    .wb_rd     (wb_rd)
  );

endmodule
